// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
// Module   : timer_bank
// Brief    : Sixteen-slot countdown timer bank with a 1 Hz prescaler, producing
//            the packed 256-bit data_raw vector for the text generator.
//            Optional macro TIMER_BANK_STICKY_EXPIRE_EN makes expiry flags sticky.
// Revision : 1.0 - initial release
// ============================================================================
module timer_bank #(
    parameter int TICK_DIV = 100000000,
    parameter int STEP_SEC = 60,
    parameter int MAX_SEC  = 5999
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   sw,
    input  logic         start_stop_p,
    input  logic         inc_p,
    input  logic         dec_p,
    input  logic         clr_p,
    output logic [255:0] data_raw,
    output logic [15:0]  running,
    output logic [15:0]  expired,
    output logic         tick
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } slot_state_e;

    localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [16:0]     STEP_17  = 17'(STEP_SEC);
    localparam logic [16:0]     MAX_17   = 17'(MAX_SEC);

    logic [CNT_W-1:0] presc_q, presc_d;
    logic             tick_q, tick_d;

    always_comb begin
        presc_d = (presc_q == CNT_LAST) ? '0 : presc_q + CNT_W'(1);
        tick_d  = (presc_q == CNT_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

    generate
        for (genvar k = 0; k < 16; k++) begin : g_slot
            localparam int R = k / 4;
            localparam int C = k % 4;

            slot_state_e state_q, state_d;
            logic [15:0] value_q, value_d;
            logic        exp_q, exp_d;
            logic        sel_w;
            logic        act_w;
            logic [16:0] sum_w;

            assign sel_w = sw[R] & sw[4+C];
            // Any button on a selected slot, even a cancelled inc+dec, eats the tick.
            assign act_w = sel_w & (clr_p | inc_p | dec_p | start_stop_p);
            assign sum_w = {1'b0, value_q} + STEP_17;

            always_comb begin
                state_d = state_q;
                value_d = value_q;
`ifdef TIMER_BANK_STICKY_EXPIRE_EN
                exp_d   = exp_q & ~(sel_w & (clr_p | start_stop_p));
`else
                exp_d   = 1'b0;
`endif
                if (sel_w && clr_p) begin
                    value_d = '0;
                    state_d = ST_IDLE;
                end else if (sel_w && (inc_p ^ dec_p)) begin
                    if (inc_p) begin
                        value_d = (sum_w > MAX_17) ? MAX_17[15:0] : sum_w[15:0];
                    end else if ({1'b0, value_q} > STEP_17) begin
                        value_d = value_q - STEP_17[15:0];
                    end else begin
                        value_d = '0;
                        state_d = ST_IDLE;
                    end
                end else if (sel_w && start_stop_p) begin
                    case (state_q)
                        ST_IDLE: if (value_q != '0) state_d = ST_RUN;
                        ST_RUN:  state_d = ST_IDLE;
                        default: state_d = ST_IDLE;
                    endcase
                end else if (!act_w && tick_q && (state_q == ST_RUN)) begin
                    value_d = value_q - 16'd1;
                    if (value_q == 16'd1) begin
                        state_d = ST_IDLE;
                        exp_d   = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q <= ST_IDLE;
                    value_q <= '0;
                    exp_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    value_q <= value_d;
                    exp_q   <= exp_d;
                end
            end

            assign data_raw[255-16*k -: 16] = value_q;
            assign running[k]               = (state_q == ST_RUN);
            assign expired[k]               = exp_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_timer_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_bank
// Brief    : Randomized bench for timer_bank against a slot-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_bank;

    localparam int TICK_DIV = 10;
    localparam int STEP_SEC = 60;
    localparam int MAX_SEC  = 5999;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   sw;
    logic         start_stop_p, inc_p, dec_p, clr_p;
    logic [255:0] data_raw;
    logic [15:0]  running, expired;
    logic         tick;

    int n_tests = 0;
    int n_fail  = 0;

    int m_val [16];
    bit m_run [16];
    bit m_exp [16];
    int m_cnt;
    bit m_tick;

    timer_bank #(
        .TICK_DIV(TICK_DIV),
        .STEP_SEC(STEP_SEC),
        .MAX_SEC (MAX_SEC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw          (sw),
        .start_stop_p(start_stop_p),
        .inc_p       (inc_p),
        .dec_p       (dec_p),
        .clr_p       (clr_p),
        .data_raw    (data_raw),
        .running     (running),
        .expired     (expired),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 16; k++) begin
            m_val[k] = 0;
            m_run[k] = 0;
            m_exp[k] = 0;
        end
        m_cnt  = 0;
        m_tick = 0;
    endtask

    task automatic m_advance(input logic [7:0] s, input bit ss, input bit in, input bit de, input bit cl);
        for (int k = 0; k < 16; k++) begin
            bit sel;
            sel = s[k/4] && s[4 + k%4];
`ifdef TIMER_BANK_STICKY_EXPIRE_EN
            if (sel && (cl || ss)) m_exp[k] = 0;
`else
            m_exp[k] = 0;
`endif
            if (sel && cl) begin
                m_val[k] = 0;
                m_run[k] = 0;
            end else if (sel && (in != de)) begin
                if (in) begin
                    m_val[k] = (m_val[k] + STEP_SEC > MAX_SEC) ? MAX_SEC : m_val[k] + STEP_SEC;
                end else begin
                    m_val[k] = (m_val[k] > STEP_SEC) ? m_val[k] - STEP_SEC : 0;
                    if (m_val[k] == 0) m_run[k] = 0;
                end
            end else if (sel && ss) begin
                if (m_run[k]) m_run[k] = 0;
                else if (m_val[k] > 0) m_run[k] = 1;
            end else if (!(sel && (in || de)) && m_tick && m_run[k]) begin
                m_val[k] = m_val[k] - 1;
                if (m_val[k] == 0) begin
                    m_run[k] = 0;
                    m_exp[k] = 1;
                end
            end
        end
        m_tick = (m_cnt == TICK_DIV - 1);
        m_cnt  = (m_cnt + 1) % TICK_DIV;
    endtask

    task automatic check_all();
        logic [255:0] ev;
        logic [15:0]  er, ee;
        for (int k = 0; k < 16; k++) begin
            ev[255-16*k -: 16] = 16'(m_val[k]);
            er[k] = m_run[k];
            ee[k] = m_exp[k];
        end
        chk("data_raw", data_raw, ev);
        chk("running", {240'd0, running}, {240'd0, er});
        chk("expired", {240'd0, expired}, {240'd0, ee});
        chk("tick", {255'd0, tick}, {255'd0, m_tick});
    endtask

    // One clock: drive pulses, advance the model, compare after the edge.
    task automatic step(input logic [7:0] s, input bit ss, input bit in, input bit de, input bit cl);
        sw           = s;
        start_stop_p = ss;
        inc_p        = in;
        dec_p        = de;
        clr_p        = cl;
        m_advance(s, ss, in, de, cl);
        @(posedge clk);
        #1;
        check_all();
        start_stop_p = 0;
        inc_p        = 0;
        dec_p        = 0;
        clr_p        = 0;
    endtask

    task automatic idle();
        step(sw, 0, 0, 0, 0);
    endtask

    // Step until n ticks have been applied to running slots.
    task automatic run_ticks(input int n);
        int seen;
        seen = m_tick ? 1 : 0;
        for (int i = 0; i < n * TICK_DIV + TICK_DIV + 2 && seen < n; i++) begin
            idle();
            if (m_tick) seen++;
        end
        idle();
    endtask

    task automatic wait_tick_high();
        for (int i = 0; i < 2 * TICK_DIV && !m_tick; i++) idle();
    endtask

    initial begin
        reset        = 1;
        sw           = 8'h00;
        start_stop_p = 0;
        inc_p        = 0;
        dec_p        = 0;
        clr_p        = 0;
        m_reset();
        #22;
        reset = 0;
        chk("rst_data", data_raw, 256'd0);
        chk("rst_running", {240'd0, running}, 256'd0);
        chk("rst_tick", {255'd0, tick}, 256'd0);

        // Prescaler cadence
        for (int i = 0; i < 9; i++) idle();
        chk("tick_before_10", {255'd0, tick}, 256'd0);
        idle();
        chk("tick_at_10", {255'd0, tick}, 256'd1);
        idle();
        chk("tick_one_cycle", {255'd0, tick}, 256'd0);

        // Increment and saturation
        step(8'h11, 0, 1, 0, 0);
        step(8'h11, 0, 1, 0, 0);
        chk("slot0_120", {240'd0, data_raw[255:240]}, 256'd120);
        chk("others_zero", {16'd0, data_raw[239:0]}, 256'd0);
        for (int i = 0; i < 200; i++) step(8'h88, 0, 1, 0, 0);
        chk("slot15_sat", {240'd0, data_raw[15:0]}, 256'd5999);

        // Run, stop, hold
        step(8'h11, 1, 0, 0, 0);
        chk("slot0_run", {255'd0, running[0]}, 256'd1);
        run_ticks(3);
        chk("slot0_117", {240'd0, data_raw[255:240]}, 256'd117);
        step(8'h11, 1, 0, 0, 0);
        chk("slot0_stop", {255'd0, running[0]}, 256'd0);
        run_ticks(5);
        chk("slot0_hold", {240'd0, data_raw[255:240]}, 256'd117);

        // Expiry on slot 5
        step(8'h22, 0, 1, 0, 0);
        step(8'h22, 1, 0, 0, 0);
        run_ticks(58);
        chk("slot5_2", {240'd0, data_raw[175:160]}, 256'd2);
        run_ticks(2);
        chk("slot5_0", {240'd0, data_raw[175:160]}, 256'd0);
        chk("slot5_idle", {255'd0, running[5]}, 256'd0);
        chk("slot5_exp", {255'd0, expired[5]}, 256'd1);
        idle();
`ifdef TIMER_BANK_STICKY_EXPIRE_EN
        chk("slot5_sticky", {255'd0, expired[5]}, 256'd1);
        step(8'h22, 0, 0, 0, 1);
        chk("slot5_exp_clr", {255'd0, expired[5]}, 256'd0);
`else
        chk("slot5_exp_pulse", {255'd0, expired[5]}, 256'd0);
`endif

        // inc+dec together on a tick cycle, then clr beats inc
        step(8'h11, 0, 0, 0, 1);
        step(8'h11, 0, 1, 0, 0);
        wait_tick_high();
        step(8'h11, 1, 0, 0, 0);
        wait_tick_high();
        step(8'h11, 0, 1, 1, 0);
        chk("incdec_hold", {240'd0, data_raw[255:240]}, 256'd60);
        chk("incdec_run", {255'd0, running[0]}, 256'd1);
        step(8'h11, 0, 1, 0, 1);
        chk("clr_inc_val", {240'd0, data_raw[255:240]}, 256'd0);
        chk("clr_inc_idle", {255'd0, running[0]}, 256'd0);

        // All slots, then asynchronous reset while running
        step(8'hFF, 0, 0, 0, 1);
        step(8'hFF, 0, 1, 0, 0);
        chk("all_60", data_raw, {16{16'd60}});
        step(8'hFF, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) idle();
        #2;
        reset = 1;
        #1;
        chk("async_data", data_raw, 256'd0);
        chk("async_running", {240'd0, running}, 256'd0);
        chk("async_expired", {240'd0, expired}, 256'd0);
        chk("async_tick", {255'd0, tick}, 256'd0);
        m_reset();
        @(posedge clk);
        #1;
        reset = 0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(8'($urandom),
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 6) == 0,
                 $urandom_range(0, 20) == 0);
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) idle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
